// File: rtl/chart_sequencer.sv
// Song-chart scheduler: walks a synchronous-read chart ROM and emits one
// arrow-spawn pulse per entry, holding each for its sixteenth-tick duration.
module chart_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 4,
  parameter int DUR_W  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   pause_i,
  input  logic                   sixteenth_i,
  output logic [ADDR_W-1:0]      rom_addr_o,
  input  logic [LANES+DUR_W-1:0] rom_data_i,
  output logic                   spawn_valid_o,
  output logic [LANES-1:0]       spawn_arrows_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_spawn;
  logic              w_spawn_nxt;
  logic [LANES-1:0]  r_arrows;
  logic [LANES-1:0]  w_arrows_nxt;
  logic [DUR_W-1:0]  r_rem;
  logic [DUR_W-1:0]  w_rem_nxt;
  logic              r_pend;
  logic              w_pend_nxt;

  logic              w_tick;
  logic              w_last;
  logic [DUR_W-1:0]  w_dur;
  logic [LANES-1:0]  w_mask;

  assign w_tick = sixteenth_i & ~pause_i;
  assign w_last = &r_addr;
  assign w_dur  = rom_data_i[DUR_W-1:0];
  assign w_mask = rom_data_i[LANES+DUR_W-1:DUR_W];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_spawn  <= 1'b0;
      r_arrows <= '0;
      r_rem    <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_spawn  <= w_spawn_nxt;
      r_arrows <= w_arrows_nxt;
      r_rem    <= w_rem_nxt;
      r_pend   <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_spawn_nxt  = 1'b0;
    w_arrows_nxt = r_arrows;
    w_rem_nxt    = r_rem;
    w_pend_nxt   = r_pend;
    if (abort_i) begin
      w_state_nxt  = S_IDLE;
      w_addr_nxt   = '0;
      w_arrows_nxt = '0;
      w_rem_nxt    = '0;
      w_pend_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_pend_nxt = 1'b0;
          if (start_i) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
          end
        end
        S_FETCH: begin
          w_state_nxt = S_WAIT;
          if (w_tick) w_pend_nxt = 1'b1;
        end
        S_WAIT: begin
          if (w_tick) w_pend_nxt = 1'b1;
          if (w_dur == '0) begin
            w_state_nxt = S_DONE;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt  = S_HOLD;
            w_spawn_nxt  = 1'b1;
            w_arrows_nxt = w_mask;
            w_rem_nxt    = w_dur;
          end
        end
        S_HOLD: begin
          // A latched tick and a live tick in the same cycle still count once.
          if (w_tick | r_pend) begin
            w_pend_nxt = 1'b0;
            if (r_rem != DUR_W'(1)) begin
              w_rem_nxt = r_rem - DUR_W'(1);
            end else if (!w_last) begin
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          w_pend_nxt = 1'b0;
          if (start_i) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o     = r_addr;
  assign spawn_valid_o  = r_spawn;
  assign spawn_arrows_o = r_arrows;
  assign busy_o         = (r_state == S_FETCH) |
                          (r_state == S_WAIT)  |
                          (r_state == S_HOLD);
  assign done_o         = (r_state == S_DONE);

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: an 8-bit-address instance with a
// terminated chart and a 2-bit-address instance with an unterminated chart.
module tb_chart_sequencer;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i, abort_i, pause_i, sixteenth_i;
  logic       start2, abort2;
  logic [7:0] addr1;
  logic [1:0] addr2;
  logic [7:0] rom1_q, rom2_q;
  logic       sv1, sv2, busy1, busy2, done1, done2;
  logic [3:0] arr1, arr2;
  logic [7:0] rom1 [256];
  logic [7:0] rom2 [4];

  int checks = 0;
  int errors = 0;
  int cnt1 = 0;
  int cnt2 = 0;
  int b2b = 0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  int s0;

  always #5 clk = ~clk;

  chart_sequencer #(.ADDR_W(8), .LANES(4), .DUR_W(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .abort_i(abort_i), .pause_i(pause_i),
    .sixteenth_i(sixteenth_i), .rom_addr_o(addr1),
    .rom_data_i(rom1_q), .spawn_valid_o(sv1),
    .spawn_arrows_o(arr1), .busy_o(busy1), .done_o(done1)
  );

  chart_sequencer #(.ADDR_W(2), .LANES(4), .DUR_W(4)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start2),
    .abort_i(abort2), .pause_i(pause_i),
    .sixteenth_i(sixteenth_i), .rom_addr_o(addr2),
    .rom_data_i(rom2_q), .spawn_valid_o(sv2),
    .spawn_arrows_o(arr2), .busy_o(busy2), .done_o(done2)
  );

  always @(posedge clk) begin
    rom1_q <= rom1[addr1];
    rom2_q <= rom2[addr2];
  end

  always @(posedge clk) begin
    if (sv1) cnt1 <= cnt1 + 1;
    if (sv2) cnt2 <= cnt2 + 1;
    if ((sv1 && prev1) || (sv2 && prev2)) b2b <= b2b + 1;
    prev1 <= sv1;
    prev2 <= sv2;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_abort;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
  endtask

  task automatic tick_pulse;
    sixteenth_i = 1'b1;
    @(negedge clk);
    sixteenth_i = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (addr1 !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr1); end
    checks++; if (sv1 !== 1'b0) begin errors++; $display("FAIL reset_spawn: got %b want 0", sv1); end
    checks++; if (arr1 !== 4'd0) begin errors++; $display("FAIL reset_arrows: got %b want 0000", arr1); end
    checks++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b want 00", {busy1, done1}); end
  endtask

  task automatic test_basic;
    s0 = cnt1;
    do_start;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy1); end
    cyc(1);
    checks++; if (sv1 !== 1'b0) begin errors++; $display("FAIL basic_early_spawn: got %b want 0", sv1); end
    cyc(1);
    checks++; if ({sv1, arr1} !== 5'b1_0001) begin errors++; $display("FAIL basic_spawn0: got %b want 10001", {sv1, arr1}); end
    cyc(1);
    checks++; if ({sv1, arr1} !== 5'b0_0001) begin errors++; $display("FAIL basic_spawn0_hold: got %b want 00001", {sv1, arr1}); end
    cyc(17);
    tick_pulse;
    checks++; if (addr1 !== 8'd0) begin errors++; $display("FAIL basic_tick1_addr: got %0d want 0", addr1); end
    cyc(19);
    tick_pulse;
    checks++; if (addr1 !== 8'd1) begin errors++; $display("FAIL basic_tick2_addr: got %0d want 1", addr1); end
    cyc(2);
    checks++; if ({sv1, arr1} !== 5'b1_0110) begin errors++; $display("FAIL basic_spawn1: got %b want 10110", {sv1, arr1}); end
    cyc(18);
    tick_pulse;
    checks++; if ({addr1, busy1, done1} !== {8'd2, 2'b10}) begin errors++; $display("FAIL basic_fetch_end: got %h want 0x0a", {addr1, busy1, done1}); end
    cyc(2);
    checks++; if ({busy1, done1, sv1} !== 3'b010) begin errors++; $display("FAIL basic_done: got %b want 010", {busy1, done1, sv1}); end
    checks++; if (arr1 !== 4'b0110) begin errors++; $display("FAIL basic_arrows_held: got %b want 0110", arr1); end
    checks++; if (cnt1 - s0 !== 2) begin errors++; $display("FAIL basic_spawn_count: got %0d want 2", cnt1 - s0); end
    tick_pulse;
    cyc(2);
    checks++; if ({done1, addr1} !== {1'b1, 8'd2}) begin errors++; $display("FAIL basic_done_tick_ignored: got %h want 0x102", {done1, addr1}); end
  endtask

  task automatic test_pending_tick;
    s0 = cnt1;
    do_start;
    cyc(1);
    sixteenth_i = 1'b1;
    cyc(1);
    sixteenth_i = 1'b0;
    checks++; if ({sv1, arr1} !== 5'b1_0001) begin errors++; $display("FAIL pend_spawn0: got %b want 10001", {sv1, arr1}); end
    cyc(5);
    tick_pulse;
    checks++; if (addr1 !== 8'd1) begin errors++; $display("FAIL pend_counted: got %0d want 1", addr1); end
    cyc(2);
    checks++; if ({sv1, arr1} !== 5'b1_0110) begin errors++; $display("FAIL pend_spawn1: got %b want 10110", {sv1, arr1}); end
    tick_pulse;
    cyc(2);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL pend_done: got %b want 1", done1); end
    checks++; if (cnt1 - s0 !== 2) begin errors++; $display("FAIL pend_spawn_count: got %0d want 2", cnt1 - s0); end
  endtask

  task automatic test_pending_overlap;
    do_start;
    cyc(1);
    sixteenth_i = 1'b1;
    cyc(2);
    sixteenth_i = 1'b0;
    cyc(3);
    checks++; if ({busy1, addr1} !== {1'b1, 8'd0}) begin errors++; $display("FAIL overlap_once: got %h want 0x100", {busy1, addr1}); end
    tick_pulse;
    checks++; if (addr1 !== 8'd1) begin errors++; $display("FAIL overlap_next: got %0d want 1", addr1); end
    do_abort;
  endtask

  task automatic test_pause;
    do_start;
    cyc(2);
    pause_i = 1'b1;
    repeat (3) begin
      cyc(3);
      tick_pulse;
    end
    checks++; if ({busy1, addr1} !== {1'b1, 8'd0}) begin errors++; $display("FAIL pause_frozen: got %h want 0x100", {busy1, addr1}); end
    pause_i = 1'b0;
    cyc(2);
    tick_pulse;
    checks++; if (addr1 !== 8'd0) begin errors++; $display("FAIL pause_first_tick: got %0d want 0", addr1); end
    cyc(2);
    tick_pulse;
    checks++; if (addr1 !== 8'd1) begin errors++; $display("FAIL pause_second_tick: got %0d want 1", addr1); end
    cyc(2);
    checks++; if ({sv1, arr1} !== 5'b1_0110) begin errors++; $display("FAIL pause_spawn1: got %b want 10110", {sv1, arr1}); end
    do_abort;
  endtask

  task automatic test_abort;
    do_start;
    cyc(5);
    s0 = cnt1;
    do_start;
    cyc(4);
    checks++; if (cnt1 - s0 !== 0) begin errors++; $display("FAIL abort_start_busy_ignored: got %0d want 0 spawns", cnt1 - s0); end
    do_abort;
    checks++; if ({busy1, done1, sv1, arr1, addr1} !== 15'd0) begin errors++; $display("FAIL abort_clear: got %h want 0", {busy1, done1, sv1, arr1, addr1}); end
    start_i = 1'b1;
    abort_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    abort_i = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_wins: got %b want 0", busy1); end
    tick_pulse;
    do_start;
    cyc(2);
    checks++; if ({sv1, arr1, addr1} !== {5'b1_0001, 8'd0}) begin errors++; $display("FAIL abort_restart: got %h want 0x1100", {sv1, arr1, addr1}); end
    cyc(2);
    tick_pulse;
    checks++; if (addr1 !== 8'd0) begin errors++; $display("FAIL abort_idle_tick_ignored: got %0d want 0", addr1); end
    do_abort;
  endtask

  task automatic test_no_wrap;
    logic [3:0] exp_m;
    start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    cyc(2);
    checks++; if ({sv2, arr2, addr2} !== 7'b1_0001_00) begin errors++; $display("FAIL wrap_spawn0: got %b want 1000100", {sv2, arr2, addr2}); end
    for (int k = 1; k < 4; k++) begin
      exp_m = 4'b0001 << k;
      cyc(2);
      tick_pulse;
      cyc(2);
      checks++; if ({sv2, arr2, addr2} !== {1'b1, exp_m, 2'(k)}) begin errors++; $display("FAIL wrap_spawn%0d: got %b want %b", k, {sv2, arr2, addr2}, {1'b1, exp_m, 2'(k)}); end
    end
    cyc(2);
    tick_pulse;
    checks++; if ({done2, busy2, addr2} !== 4'b10_11) begin errors++; $display("FAIL wrap_done: got %b want 1011", {done2, busy2, addr2}); end
    cyc(3);
    checks++; if ({done2, addr2} !== 3'b1_11) begin errors++; $display("FAIL wrap_addr_stays: got %b want 111", {done2, addr2}); end
    checks++; if (cnt2 !== 4) begin errors++; $display("FAIL wrap_spawn_count: got %0d want 4", cnt2); end
  endtask

  task automatic test_async_reset;
    do_start;
    cyc(4);
    tick_pulse;
    cyc(2);
    tick_pulse;
    cyc(3);
    checks++; if ({busy1, addr1, arr1} !== {1'b1, 8'd1, 4'b0110}) begin errors++; $display("FAIL areset_pre: got %h want 0x1016", {busy1, addr1, arr1}); end
    #3;
    reset_i = 1'b1;
    #1;
    checks++; if ({busy1, done1, sv1, arr1, addr1} !== 15'd0) begin errors++; $display("FAIL areset_immediate: got %h want 0", {busy1, done1, sv1, arr1, addr1}); end
    checks++; if ({busy2, done2} !== 2'b00) begin errors++; $display("FAIL areset_dut2: got %b want 00", {busy2, done2}); end
    @(negedge clk);
    reset_i = 1'b0;
    do_start;
    cyc(2);
    checks++; if ({sv1, arr1, addr1} !== {5'b1_0001, 8'd0}) begin errors++; $display("FAIL areset_restart: got %h want 0x1100", {sv1, arr1, addr1}); end
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    pause_i = 1'b0;
    sixteenth_i = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    for (int i = 0; i < 256; i++) rom1[i] = 8'h00;
    rom1[0] = 8'b0001_0010;
    rom1[1] = 8'b0110_0001;
    rom1[2] = 8'b0000_0000;
    for (int i = 0; i < 4; i++) rom2[i] = {4'b0001 << i, 4'd1};
    cyc(2);
    test_reset;
    reset_i = 1'b0;
    cyc(1);
    test_basic;
    test_pending_tick;
    test_pending_overlap;
    test_pause;
    test_abort;
    test_no_wrap;
    test_async_reset;
    cyc(2);
    checks++; if (b2b !== 0) begin errors++; $display("FAIL spawn_back_to_back: got %0d want 0", b2b); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
